// File: rtl/feat_pkg.sv
// Shared definitions for the feature frame builder and the classifier-tree wrappers.
package feat_pkg;

  localparam int FEAT_W = 51;
  localparam int NBYTES = (FEAT_W + 7) / 8;

  typedef enum logic [1:0] {
    COLLECT,
    FULL,
    DROP
  } state_t;

endpackage

// File: rtl/feat_out_slot.sv
// Single-entry valid/ready output register holding one assembled feature vector.
module feat_out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] vec,
  output logic         free
);

  // The slot can take a new entry when it is empty or draining this cycle.
  assign free = !valid || ready;

  // NOTE: the data register is reset as well, because the output vector is
  // required to read zero while reset is held, not merely be qualified by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      vec   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      vec   <= data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/feature_frame_builder.sv
// Assembles byte-serial feature frames into a FEAT_W-bit vector with length checking.
module feature_frame_builder
  import feat_pkg::*;
#(
  parameter int FEAT_W = feat_pkg::FEAT_W,
  parameter int NBYTES = (FEAT_W + 7) / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              m_valid,
  output logic [FEAT_W-1:0] m_vec,
  input  logic              m_ready,
  output logic              err_len,
  output logic [15:0]       frame_cnt
);

  localparam int K_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NBYTES - 1);

  state_t            state, state_d;
  logic [K_W-1:0]    k, k_d;
  logic [FEAT_W-1:0] asm_q, asm_d, merged, slot_data;
  logic              ready_en;
  logic              accept, at_last, slot_free, load, err_d;

  assign accept  = s_valid && s_ready;
  assign at_last = (k == K_LAST);

  // Assembly with the incoming byte placed at index k; bits past FEAT_W never exist.
  always_comb begin
    merged = asm_q;
    for (int b = 0; b < FEAT_W; b++) begin
      if (k == K_W'(b / 8)) merged[b] = s_data[b % 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d = state;
    case (state)
      COLLECT: begin
        if (accept && at_last) begin
          if (!s_last)         state_d = DROP;
          else if (!slot_free) state_d = FULL;
        end
      end
      FULL:    if (slot_free) state_d = COLLECT;
      DROP:    if (accept && s_last) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    s_ready = ready_en && (state != FULL);
    load    = 1'b0;
    err_d   = 1'b0;
    k_d     = k;
    asm_d   = asm_q;
    case (state)
      COLLECT: begin
        if (accept) begin
          asm_d = merged;
          if (s_last || at_last) begin
            k_d = '0;
            if (s_last && at_last) load  = slot_free;
            else                   err_d = 1'b1;
          end else begin
            k_d = k + K_W'(1);
          end
        end
      end
      FULL:    load = slot_free;
      DROP:    k_d  = '0;
      default: k_d  = '0;
    endcase
  end

  // A parked frame comes from the assembly register; a fresh one bypasses it.
  assign slot_data = (state == FULL) ? asm_q : merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en  <= 1'b0;
      k         <= '0;
      asm_q     <= '0;
      err_len   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      ready_en <= 1'b1;
      k        <= k_d;
      asm_q    <= asm_d;
      err_len  <= err_d;
      if (m_valid && m_ready) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  feat_out_slot #(
    .W(FEAT_W)
  ) u_out_slot (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .data (slot_data),
    .ready(m_ready),
    .valid(m_valid),
    .vec  (m_vec),
    .free (slot_free)
  );

endmodule

// File: tb/tb_feature_frame_builder.sv
// Self-checking bench: randomized byte streams scored against a frame-level model.
module tb_feature_frame_builder;
  import feat_pkg::*;

  localparam int W  = FEAT_W;
  localparam int NB = NBYTES;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_last, s_ready;
  logic [7:0]    s_data;
  logic          m_valid, m_ready, err_len;
  logic [W-1:0]  m_vec;
  logic [15:0]   frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference model
  logic [7:0]   cur_bytes[$];
  bit           dropping;
  logic [W-1:0] exp_q[$];
  int           exp_err = 0;
  int           obs_err = 0;
  int           produced = 0;

  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_vec;
  logic [W-1:0] exp_vec;

  always #5 clk = ~clk;

  feature_frame_builder #(.FEAT_W(W), .NBYTES(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_vec    (m_vec),
    .m_ready  (m_ready),
    .err_len  (err_len),
    .frame_cnt(frame_cnt)
  );

  task automatic model_reset();
    cur_bytes.delete();
    exp_q.delete();
    dropping = 1'b0;
    produced = 0;
  endtask

  task automatic model_byte(input logic [7:0] d, input logic l);
    logic [63:0] v;
    if (dropping) begin
      if (l) dropping = 1'b0;
      return;
    end
    cur_bytes.push_back(d);
    if (l) begin
      if (cur_bytes.size() == NB) begin
        v = 64'd0;
        foreach (cur_bytes[i]) v = v | (64'(cur_bytes[i]) << (8 * i));
        exp_q.push_back(v[W-1:0]);
        produced++;
      end else begin
        exp_err++;
      end
      cur_bytes.delete();
    end else if (cur_bytes.size() == NB) begin
      exp_err++;
      dropping = 1'b1;
      cur_bytes.delete();
    end
  endtask

  // Output scoreboard and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_len) obs_err++;
      if (prev_hold) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_vec !== prev_vec) begin
          n_fail++;
          $display("FAIL hold_stable: got valid=%b vec=%h, required valid=1 vec=%h", m_valid, m_vec, prev_vec);
        end
      end
      if (m_valid && m_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame: got vec=%h, required no transfer", m_vec);
        end else begin
          exp_vec = exp_q.pop_front();
          if (m_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL frame_data: got %h, required %h", m_vec, exp_vec);
          end
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_vec  = m_vec;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l, input bit rand_rdy);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk);
      #1;
      if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (done) model_byte(d, l);
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted within 500 cycles", d);
    end
  endtask

  task automatic send_frame(input int len, input bit rand_rdy);
    for (int i = 0; i < len; i++) send_byte(8'($urandom), i == len - 1, rand_rdy);
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !m_valid;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: %0d frames still expected, m_valid=%b", name, exp_q.size(), m_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({s_ready, m_valid, err_len} !== 3'b000 || m_vec !== '0 || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL %s: got s_ready=%b m_valid=%b err_len=%b m_vec=%h frame_cnt=%0d, required all zero",
               name, s_ready, m_valid, err_len, m_vec, frame_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b, required 0", s_ready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge: got %b, required 1", s_ready);
    end
  endtask

  task automatic test_all_ones();
    m_ready = 1'b1;
    for (int i = 0; i < NB - 1; i++) send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'h07, 1'b1, 1'b0);
    n_checks++;
    if (m_valid !== 1'b1 || m_vec !== 51'h7FFFFFFFFFFFF) begin
      n_fail++;
      $display("FAIL all_ones_latency: got valid=%b vec=%h, required valid=1 vec=7ffffffffffff", m_valid, m_vec);
    end
    drain("all_ones");
    n_checks++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL all_ones_count: got %0d, required 1", frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b0;
    send_frame(NB, 1'b0);
    send_frame(NB, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_vec !== exp_q[0]) begin
      n_fail++;
      $display("FAIL parked_full: got s_ready=%b m_valid=%b vec=%h, required s_ready=0 m_valid=1 vec=%h",
               s_ready, m_valid, m_vec, exp_q[0]);
    end
    drain("back_to_back");
    n_checks++;
    if (frame_cnt !== 16'(produced)) begin
      n_fail++;
      $display("FAIL back_to_back_count: got %0d, required %0d", frame_cnt, produced);
    end
  endtask

  task automatic test_length_error(input string name, input int len);
    int e0 = obs_err;
    m_ready = 1'b1;
    send_frame(len, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_err - e0 !== 1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_err: got %0d pulses m_valid=%b, required 1 pulse m_valid=0", name, obs_err - e0, m_valid);
    end
    send_frame(NB, 1'b0);
    drain(name);
    n_checks++;
    if (frame_cnt !== 16'(produced) || exp_err !== obs_err) begin
      n_fail++;
      $display("FAIL %s_recover: got cnt=%0d err=%0d, required cnt=%0d err=%0d",
               name, frame_cnt, obs_err, produced, exp_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0 = obs_err;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    #2 rst = 1'b1;
    s_valid = 1'b0;
    model_reset();
    #1;
    check_idle_outputs("mid_frame_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(NB, 1'b0);
    drain("after_reset");
    n_checks++;
    if (frame_cnt !== 16'd1 || obs_err !== e0) begin
      n_fail++;
      $display("FAIL after_reset: got cnt=%0d err_pulses=%0d, required cnt=1 err_pulses=0", frame_cnt, obs_err - e0);
    end
  endtask

  task automatic test_random();
    int kind;
    for (int f = 0; f < 150; f++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      send_frame(int'($urandom_range(1, NB - 1)), 1'b1);
      else if (kind == 1) send_frame(int'($urandom_range(NB + 1, NB + 3)), 1'b1);
      else                send_frame(NB, 1'b1);
    end
    drain("random");
    n_checks++;
    if (frame_cnt !== 16'(produced) || exp_err !== obs_err) begin
      n_fail++;
      $display("FAIL random_totals: got cnt=%0d err=%0d, required cnt=%0d err=%0d",
               frame_cnt, obs_err, produced, exp_err);
    end
  endtask

  task automatic test_wrap();
    int p0 = produced;
    m_ready = 1'b1;
    force dut.frame_cnt = 16'hFFFD;
    #1 release dut.frame_cnt;
    @(posedge clk);
    #1;
    for (int f = 0; f < 2; f++) send_frame(NB, 1'b0);
    drain("wrap_pre");
    n_checks++;
    if (frame_cnt !== 16'(16'hFFFD + produced - p0)) begin
      n_fail++;
      $display("FAIL wrap_pre: got %h, required ffff", frame_cnt);
    end
    send_frame(NB, 1'b0);
    drain("wrap");
    n_checks++;
    if (frame_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap: got %h, required 0000", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_back_to_back();
    test_length_error("short_frame", 4);
    test_length_error("long_frame", NB + 1);
    test_reset_mid_frame();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/feature_frame_builder.md
FEATURE_FRAME_BUILDER -- requirements
Module: feature_frame_builder

Interface
REQ-001 Parameter FEAT_W, default 51, SHALL set the width of the assembled feature vector.
REQ-002 Parameter NBYTES, default 7 (ceil(FEAT_W/8)), SHALL set the number of input bytes per frame.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 s_valid  input  1  SHALL indicate that the upstream byte is valid.
REQ-006 s_data  input  8  SHALL carry the feature byte, LSB = lowest feature index.
REQ-007 s_last  input  1  SHALL mark the final byte of a frame.
REQ-008 s_ready  output  1  SHALL indicate that the block accepts a byte this cycle.
REQ-009 m_valid  output  1  SHALL indicate that m_vec holds a complete frame for the classifier trees.
REQ-010 m_vec  output  FEAT_W  SHALL carry the feature vector i[50:0].
REQ-011 m_ready  input  1  SHALL indicate that the classifier side consumes m_vec this cycle.
REQ-012 err_len  output  1  SHALL pulse for one cycle on a frame-length violation.
REQ-013 frame_cnt  output  16  SHALL count frames delivered on m_* and wrap at 65535->0.

Function
REQ-014 A byte SHALL be accepted only in a cycle with s_valid=1 and s_ready=1; a transfer on m_* SHALL occur only with m_valid=1 and m_ready=1.
REQ-015 Accepted byte index k (0..NBYTES-1) SHALL be written to assembly bits [8k+7:8k]; bits at or above FEAT_W SHALL be discarded (byte 6 bits 3..7 ignored).
REQ-016 The state machine SHALL have the states COLLECT, FULL (assembly complete, output slot occupied), and DROP (discarding to resync).
REQ-017 In COLLECT, s_ready SHALL be 1; in FULL, it SHALL be 0; in DROP, it SHALL be 1.
REQ-018 When byte k=NBYTES-1 with s_last=1 is accepted, and the output slot is empty or drained in the same cycle, m_vec SHALL load and m_valid SHALL be 1 on the next cycle (1-cycle latency), and the state SHALL return to COLLECT with k=0.
REQ-019 If the output slot is occupied and not drained in that cycle, the state SHALL enter FULL; in the cycle the slot drains, the assembly SHALL transfer to m_vec, m_valid SHALL stay 1 on the next cycle, and the state SHALL return to COLLECT.
REQ-020 m_vec and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-021 m_valid SHALL fall on the cycle after a transfer unless a new frame loads in the same cycle.
REQ-022 An accepted s_last with k<NBYTES-1 SHALL pulse err_len, discard the partial frame, and set k=0 while staying in COLLECT.
REQ-023 An accepted byte at k=NBYTES-1 with s_last=0 SHALL pulse err_len and enter DROP.
REQ-024 DROP SHALL discard bytes until an accepted s_last, then return to COLLECT with k=0, with no second err_len pulse.
REQ-025 frame_cnt SHALL increment once per m_* transfer.
REQ-026 err_len SHALL never assert in the same cycle as a valid frame load.

Reset
REQ-027 While rst=1: state=COLLECT, k=0, m_valid=0, m_vec=0, err_len=0, frame_cnt=0, and s_ready=0.
REQ-028 s_ready SHALL become 1 on the first clock edge after rst deasserts.
REQ-029 A reset during a partial or held frame SHALL discard the frame with no m_valid or err_len.

Structure
REQ-030 Package feat_pkg SHALL hold FEAT_W, NBYTES, and the state enum type shared with the classifier-tree wrappers.
REQ-031 One sub-module, feat_out_slot, SHALL implement the single-entry valid/ready output register; all other logic SHALL be inline.

Verification
REQ-032 Bytes 0xFF x6 + 0x07 (last) with m_ready=1 -> m_vec=51'h7FFFFFFFFFFFF, m_valid 1 cycle after the last byte, frame_cnt=1.
REQ-033 Two back-to-back frames with m_ready=0 -> the second frame parks in FULL with s_ready=0; after m_ready=1 -> frame 1 then frame 2 delivered, frame_cnt=2.
REQ-034 s_last on byte 3 -> err_len pulses once, no m_valid; the next 7-byte frame is delivered intact.
REQ-035 8-byte frame with s_last on byte 7 -> err_len pulses at byte 6, bytes discarded, no m_valid, and the next frame is correct.
REQ-036 rst asserted mid-frame at byte 4 -> all outputs zero immediately; a following full frame is delivered correctly.
REQ-037 Deliver 65536 frames -> frame_cnt wraps to 0.
